// File: rtl/pdp8_mem_arb_ctrl.sv
// Multi-channel arbiter in front of a single-port word memory for the PDP-8 datapath.
// Grants one request per cycle and returns each read response to its channel RD_LAT cycles after the accept edge.
module pdp8_mem_arb_ctrl #(
  parameter int NUM_CH     = 3,
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 12,
  parameter int RD_LAT     = 2,
  parameter int ARB_MODE   = 0
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NUM_CH-1:0]            req,
  input  logic [NUM_CH-1:0]            we,
  input  logic [NUM_CH*ADDR_WIDTH-1:0] addr,
  input  logic [NUM_CH*DATA_WIDTH-1:0] wdata,
  output logic [NUM_CH-1:0]            gnt,
  output logic [NUM_CH-1:0]            rvalid,
  output logic [DATA_WIDTH-1:0]        rdata,
  output logic [15:0]                  acc_cnt
);

  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int SUM_W = CH_W + 1;
  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [SUM_W-1:0] NUM_CH_S = SUM_W'(NUM_CH);
  localparam logic [CH_W-1:0]  LAST_CH  = CH_W'(NUM_CH - 1);

  logic [CH_W-1:0]       rr_ptr;
  logic [CH_W-1:0]       gnt_idx;
  logic                  any_gnt;
  logic [SUM_W-1:0]      cand_sum;
  logic [CH_W-1:0]       cand;

  logic                  sel_we;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_wdata;
  logic                  acc_rd;
  logic                  acc_wr;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic                  pipe_vld  [RD_LAT];
  logic [CH_W-1:0]       pipe_ch   [RD_LAT];
  logic [DATA_WIDTH-1:0] pipe_data [RD_LAT];

  // Round-robin search starts at the pointer and wraps; fixed priority starts at channel 0.
  always_comb begin
    any_gnt  = 1'b0;
    gnt_idx  = '0;
    cand_sum = '0;
    cand     = '0;
    for (int off = 0; off < NUM_CH; off++) begin
      if (ARB_MODE == 1) begin
        cand_sum = {1'b0, rr_ptr} + SUM_W'(off);
        if (cand_sum >= NUM_CH_S) begin
          cand_sum = cand_sum - NUM_CH_S;
        end
      end else begin
        cand_sum = SUM_W'(off);
      end
      cand = cand_sum[CH_W-1:0];
      if (!any_gnt && req[cand]) begin
        any_gnt = 1'b1;
        gnt_idx = cand;
      end
    end
    if (reset) begin
      any_gnt = 1'b0;
      gnt_idx = '0;
    end
  end

  always_comb begin
    gnt = '0;
    if (any_gnt) begin
      gnt = NUM_CH'(1) << gnt_idx;
    end
  end

  always_comb begin
    sel_we    = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (gnt[i]) begin
        sel_we    = we[i];
        sel_addr  = addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        sel_wdata = wdata[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign acc_rd = any_gnt & ~sel_we;
  assign acc_wr = any_gnt & sel_we;

  // Memory and the data half of the read pipeline carry no reset so the array stays a plain RAM.
  always_ff @(posedge clk) begin
    if (acc_wr) begin
      mem[sel_addr] <= sel_wdata;
    end
    pipe_data[0] <= mem[sel_addr];
    for (int i = 1; i < RD_LAT; i++) begin
      pipe_data[i] <= pipe_data[i-1];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < RD_LAT; i++) begin
        pipe_vld[i] <= 1'b0;
        pipe_ch[i]  <= '0;
      end
    end else begin
      pipe_vld[0] <= acc_rd;
      pipe_ch[0]  <= gnt_idx;
      for (int i = 1; i < RD_LAT; i++) begin
        pipe_vld[i] <= pipe_vld[i-1];
        pipe_ch[i]  <= pipe_ch[i-1];
      end
    end
  end

  // rdata only updates when a response is due so it holds the last returned word.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rvalid <= '0;
      rdata  <= '0;
    end else begin
      rvalid <= '0;
      if (pipe_vld[RD_LAT-1]) begin
        rvalid <= NUM_CH'(1) << pipe_ch[RD_LAT-1];
        rdata  <= pipe_data[RD_LAT-1];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_cnt <= '0;
    end else if (any_gnt && (acc_cnt != 16'hFFFF)) begin
      acc_cnt <= acc_cnt + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_ptr <= '0;
    end else if (any_gnt) begin
      rr_ptr <= (gnt_idx == LAST_CH) ? '0 : gnt_idx + CH_W'(1);
    end
  end

endmodule

// File: tb/tb_pdp8_mem_arb_ctrl.sv
// Directed bench: one fixed-priority RD_LAT=2 instance and one round-robin RD_LAT=4 instance share stimulus.
// Expected grants, responses and counts are worked out by hand per cycle.
module tb_pdp8_mem_arb_ctrl;

  logic        clk;
  logic        reset;
  logic [2:0]  req;
  logic [2:0]  we;
  logic [35:0] addr;
  logic [35:0] wdata;

  logic [2:0]  gnt_a, gnt_b;
  logic [2:0]  rvalid_a, rvalid_b;
  logic [11:0] rdata_a, rdata_b;
  logic [15:0] cnt_a, cnt_b;

  int checks;
  int failures;

  typedef struct packed {
    logic        rst;
    logic [2:0]  req;
    logic [2:0]  we;
    logic [35:0] addr;
    logic [35:0] wdata;
    logic [2:0]  gnt_a;
    logic [2:0]  gnt_b;
    logic [2:0]  rv_a;
    logic [2:0]  rv_b;
    logic [11:0] rd_a;
    logic [11:0] rd_b;
    logic [15:0] cnt;
  } vec_t;

  vec_t tbl [32];

  pdp8_mem_arb_ctrl #(
    .NUM_CH(3), .ADDR_WIDTH(12), .DATA_WIDTH(12), .RD_LAT(2), .ARB_MODE(0)
  ) dut_a (
    .clk(clk), .reset(reset), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .gnt(gnt_a), .rvalid(rvalid_a), .rdata(rdata_a), .acc_cnt(cnt_a)
  );

  pdp8_mem_arb_ctrl #(
    .NUM_CH(3), .ADDR_WIDTH(12), .DATA_WIDTH(12), .RD_LAT(4), .ARB_MODE(1)
  ) dut_b (
    .clk(clk), .reset(reset), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .gnt(gnt_b), .rvalid(rvalid_b), .rdata(rdata_b), .acc_cnt(cnt_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic vec_t mk(
    input logic rst, input logic [2:0] rq, input logic [2:0] w,
    input logic [11:0] a0, input logic [11:0] a1, input logic [11:0] a2,
    input logic [11:0] d0, input logic [11:0] d1, input logic [11:0] d2,
    input logic [2:0] ga, input logic [2:0] gb,
    input logic [2:0] rva, input logic [2:0] rvb,
    input logic [11:0] rda, input logic [11:0] rdb,
    input logic [15:0] cnt);
    vec_t v;
    v.rst = rst; v.req = rq; v.we = w;
    v.addr = {a2, a1, a0};
    v.wdata = {d2, d1, d0};
    v.gnt_a = ga; v.gnt_b = gb;
    v.rv_a = rva; v.rv_b = rvb;
    v.rd_a = rda; v.rd_b = rdb;
    v.cnt = cnt;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Called at a falling edge: drive, check grants, then check registered outputs just after the rising edge.
  task automatic applyStimulus(input vec_t v, input string tag);
    reset = v.rst;
    req   = v.req;
    we    = v.we;
    addr  = v.addr;
    wdata = v.wdata;
    #1;
    checkOutput({tag, " gnt_a"}, {29'd0, gnt_a}, {29'd0, v.gnt_a});
    checkOutput({tag, " gnt_b"}, {29'd0, gnt_b}, {29'd0, v.gnt_b});
    @(posedge clk);
    #1;
    checkOutput({tag, " rvalid_a"}, {29'd0, rvalid_a}, {29'd0, v.rv_a});
    checkOutput({tag, " rvalid_b"}, {29'd0, rvalid_b}, {29'd0, v.rv_b});
    checkOutput({tag, " rdata_a"}, {20'd0, rdata_a}, {20'd0, v.rd_a});
    checkOutput({tag, " rdata_b"}, {20'd0, rdata_b}, {20'd0, v.rd_b});
    checkOutput({tag, " acc_cnt_a"}, {16'd0, cnt_a}, {16'd0, v.cnt});
    checkOutput({tag, " acc_cnt_b"}, {16'd0, cnt_b}, {16'd0, v.cnt});
    @(negedge clk);
  endtask

  initial begin
    checks   = 0;
    failures = 0;

    // Preload addrs 0..3 with 1..4, then pipelined ch0 reads of 0..3.
    tbl[0]  = mk(0, 3'b001, 3'b001, 0, 0, 0, 1, 0, 0, 3'b001, 3'b001, 3'b000, 3'b000, 0, 0, 1);
    tbl[1]  = mk(0, 3'b001, 3'b001, 1, 0, 0, 2, 0, 0, 3'b001, 3'b001, 3'b000, 3'b000, 0, 0, 2);
    tbl[2]  = mk(0, 3'b001, 3'b001, 2, 0, 0, 3, 0, 0, 3'b001, 3'b001, 3'b000, 3'b000, 0, 0, 3);
    tbl[3]  = mk(0, 3'b001, 3'b001, 3, 0, 0, 4, 0, 0, 3'b001, 3'b001, 3'b000, 3'b000, 0, 0, 4);
    tbl[4]  = mk(0, 3'b001, 3'b000, 0, 0, 0, 0, 0, 0, 3'b001, 3'b001, 3'b000, 3'b000, 0, 0, 5);
    tbl[5]  = mk(0, 3'b001, 3'b000, 1, 0, 0, 0, 0, 0, 3'b001, 3'b001, 3'b000, 3'b000, 0, 0, 6);
    tbl[6]  = mk(0, 3'b001, 3'b000, 2, 0, 0, 0, 0, 0, 3'b001, 3'b001, 3'b001, 3'b000, 1, 0, 7);
    tbl[7]  = mk(0, 3'b001, 3'b000, 3, 0, 0, 0, 0, 0, 3'b001, 3'b001, 3'b001, 3'b000, 2, 0, 8);
    tbl[8]  = mk(0, 3'b000, 3'b000, 0, 0, 0, 0, 0, 0, 3'b000, 3'b000, 3'b001, 3'b001, 3, 1, 8);
    tbl[9]  = mk(0, 3'b000, 3'b000, 0, 0, 0, 0, 0, 0, 3'b000, 3'b000, 3'b001, 3'b001, 4, 2, 8);
    tbl[10] = mk(0, 3'b000, 3'b000, 0, 0, 0, 0, 0, 0, 3'b000, 3'b000, 3'b000, 3'b001, 4, 3, 8);
    tbl[11] = mk(0, 3'b000, 3'b000, 0, 0, 0, 0, 0, 0, 3'b000, 3'b000, 3'b000, 3'b001, 4, 4, 8);
    tbl[12] = mk(0, 3'b000, 3'b000, 0, 0, 0, 0, 0, 0, 3'b000, 3'b000, 3'b000, 3'b000, 4, 4, 8);
    // Reset clears counters and rdata, then contention with all three channels reading.
    tbl[13] = mk(1, 3'b000, 3'b000, 0, 0, 0, 0, 0, 0, 3'b000, 3'b000, 3'b000, 3'b000, 0, 0, 0);
    tbl[14] = mk(0, 3'b111, 3'b000, 0, 1, 2, 0, 0, 0, 3'b001, 3'b001, 3'b000, 3'b000, 0, 0, 1);
    tbl[15] = mk(0, 3'b111, 3'b000, 0, 1, 2, 0, 0, 0, 3'b001, 3'b010, 3'b000, 3'b000, 0, 0, 2);
    tbl[16] = mk(0, 3'b111, 3'b000, 0, 1, 2, 0, 0, 0, 3'b001, 3'b100, 3'b001, 3'b000, 1, 0, 3);
    tbl[17] = mk(0, 3'b111, 3'b000, 0, 1, 2, 0, 0, 0, 3'b001, 3'b001, 3'b001, 3'b000, 1, 0, 4);
    tbl[18] = mk(0, 3'b111, 3'b000, 0, 1, 2, 0, 0, 0, 3'b001, 3'b010, 3'b001, 3'b001, 1, 1, 5);
    tbl[19] = mk(0, 3'b111, 3'b000, 0, 1, 2, 0, 0, 0, 3'b001, 3'b100, 3'b001, 3'b010, 1, 2, 6);
    tbl[20] = mk(0, 3'b000, 3'b000, 0, 0, 0, 0, 0, 0, 3'b000, 3'b000, 3'b001, 3'b100, 1, 3, 6);
    tbl[21] = mk(0, 3'b000, 3'b000, 0, 0, 0, 0, 0, 0, 3'b000, 3'b000, 3'b001, 3'b001, 1, 1, 6);
    tbl[22] = mk(0, 3'b000, 3'b000, 0, 0, 0, 0, 0, 0, 3'b000, 3'b000, 3'b000, 3'b010, 1, 2, 6);
    tbl[23] = mk(0, 3'b000, 3'b000, 0, 0, 0, 0, 0, 0, 3'b000, 3'b000, 3'b000, 3'b100, 1, 3, 6);
    tbl[24] = mk(0, 3'b000, 3'b000, 0, 0, 0, 0, 0, 0, 3'b000, 3'b000, 3'b000, 3'b000, 1, 3, 6);
    // Round-robin pointer held across idle cycles, then moves past ch1 to ch2.
    tbl[25] = mk(0, 3'b110, 3'b000, 0, 1, 2, 0, 0, 0, 3'b010, 3'b010, 3'b000, 3'b000, 1, 3, 7);
    tbl[26] = mk(0, 3'b110, 3'b000, 0, 1, 2, 0, 0, 0, 3'b010, 3'b100, 3'b000, 3'b000, 1, 3, 8);
    tbl[27] = mk(0, 3'b000, 3'b000, 0, 0, 0, 0, 0, 0, 3'b000, 3'b000, 3'b010, 3'b000, 2, 3, 8);
    tbl[28] = mk(0, 3'b000, 3'b000, 0, 0, 0, 0, 0, 0, 3'b000, 3'b000, 3'b010, 3'b000, 2, 3, 8);
    tbl[29] = mk(0, 3'b000, 3'b000, 0, 0, 0, 0, 0, 0, 3'b000, 3'b000, 3'b000, 3'b010, 2, 2, 8);
    tbl[30] = mk(0, 3'b000, 3'b000, 0, 0, 0, 0, 0, 0, 3'b000, 3'b000, 3'b000, 3'b100, 2, 3, 8);
    tbl[31] = mk(0, 3'b000, 3'b000, 0, 0, 0, 0, 0, 0, 3'b000, 3'b000, 3'b000, 3'b000, 2, 3, 8);

    reset = 1'b0;
    req   = 3'b000;
    we    = 3'b000;
    addr  = '0;
    wdata = '0;
    #1;
    reset = 1'b1;
    req   = 3'b111;
    #1;
    checkOutput("reset gnt_a", {29'd0, gnt_a}, 32'd0);
    checkOutput("reset gnt_b", {29'd0, gnt_b}, 32'd0);
    checkOutput("reset rvalid_a", {29'd0, rvalid_a}, 32'd0);
    checkOutput("reset rdata_b", {20'd0, rdata_b}, 32'd0);
    checkOutput("reset acc_cnt_a", {16'd0, cnt_a}, 32'd0);
    checkOutput("reset acc_cnt_b", {16'd0, cnt_b}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    req   = 3'b000;

    for (int i = 0; i < 32; i++) begin
      applyStimulus(tbl[i], $sformatf("tbl%0d", i));
    end

    // ch1 write then immediate read of the same address.
    applyStimulus(mk(0, 3'b010, 3'b010, 0, 12'o0100, 0, 0, 12'o7654, 0, 3'b010, 3'b010, 3'b000, 3'b000, 2, 3, 9), "wr_rd0");
    applyStimulus(mk(0, 3'b010, 3'b000, 0, 12'o0100, 0, 0, 0, 0, 3'b010, 3'b010, 3'b000, 3'b000, 2, 3, 10), "wr_rd1");
    applyStimulus(mk(0, 3'b000, 3'b000, 0, 0, 0, 0, 0, 0, 3'b000, 3'b000, 3'b000, 3'b000, 2, 3, 10), "wr_rd2");
    applyStimulus(mk(0, 3'b000, 3'b000, 0, 0, 0, 0, 0, 0, 3'b000, 3'b000, 3'b010, 3'b000, 12'o7654, 3, 10), "wr_rd3");
    applyStimulus(mk(0, 3'b000, 3'b000, 0, 0, 0, 0, 0, 0, 3'b000, 3'b000, 3'b000, 3'b000, 12'o7654, 3, 10), "wr_rd4");
    applyStimulus(mk(0, 3'b000, 3'b000, 0, 0, 0, 0, 0, 0, 3'b000, 3'b000, 3'b000, 3'b010, 12'o7654, 12'o7654, 10), "wr_rd5");
    applyStimulus(mk(0, 3'b000, 3'b000, 0, 0, 0, 0, 0, 0, 3'b000, 3'b000, 3'b000, 3'b000, 12'o7654, 12'o7654, 10), "wr_rd6");

    // Read in flight when reset hits: it must vanish, memory must survive.
    applyStimulus(mk(0, 3'b001, 3'b000, 3, 0, 0, 0, 0, 0, 3'b001, 3'b001, 3'b000, 3'b000, 12'o7654, 12'o7654, 11), "rst0");
    applyStimulus(mk(1, 3'b001, 3'b000, 3, 0, 0, 0, 0, 0, 3'b000, 3'b000, 3'b000, 3'b000, 0, 0, 0), "rst1");
    applyStimulus(mk(1, 3'b001, 3'b000, 3, 0, 0, 0, 0, 0, 3'b000, 3'b000, 3'b000, 3'b000, 0, 0, 0), "rst2");
    for (int i = 3; i < 7; i++) begin
      applyStimulus(mk(0, 3'b000, 3'b000, 0, 0, 0, 0, 0, 0, 3'b000, 3'b000, 3'b000, 3'b000, 0, 0, 0), $sformatf("rst%0d", i));
    end
    applyStimulus(mk(0, 3'b010, 3'b000, 0, 12'o0100, 0, 0, 0, 0, 3'b010, 3'b010, 3'b000, 3'b000, 0, 0, 1), "rst7");
    applyStimulus(mk(0, 3'b001, 3'b000, 3, 0, 0, 0, 0, 0, 3'b001, 3'b001, 3'b000, 3'b000, 0, 0, 2), "rst8");
    applyStimulus(mk(0, 3'b000, 3'b000, 0, 0, 0, 0, 0, 0, 3'b000, 3'b000, 3'b010, 3'b000, 12'o7654, 0, 2), "rst9");
    applyStimulus(mk(0, 3'b000, 3'b000, 0, 0, 0, 0, 0, 0, 3'b000, 3'b000, 3'b001, 3'b000, 4, 0, 2), "rst10");
    applyStimulus(mk(0, 3'b000, 3'b000, 0, 0, 0, 0, 0, 0, 3'b000, 3'b000, 3'b000, 3'b010, 4, 12'o7654, 2), "rst11");
    applyStimulus(mk(0, 3'b000, 3'b000, 0, 0, 0, 0, 0, 0, 3'b000, 3'b000, 3'b000, 3'b001, 4, 4, 2), "rst12");
    applyStimulus(mk(0, 3'b000, 3'b000, 0, 0, 0, 0, 0, 0, 3'b000, 3'b000, 3'b000, 3'b000, 4, 4, 2), "rst13");

    // Counter saturation: ch0 held requesting for 65540 accepted reads.
    applyStimulus(mk(1, 3'b000, 3'b000, 0, 0, 0, 0, 0, 0, 3'b000, 3'b000, 3'b000, 3'b000, 0, 0, 0), "sat_rst");
    reset = 1'b0;
    req   = 3'b001;
    we    = 3'b000;
    addr  = '0;
    for (int n = 1; n <= 65540; n++) begin
      @(posedge clk);
      #1;
      if (n == 1 || n == 65534 || n == 65535 || n == 65540) begin
        checkOutput($sformatf("sat%0d acc_cnt_a", n), {16'd0, cnt_a}, (n >= 65535) ? 32'h0000FFFF : n);
        checkOutput($sformatf("sat%0d acc_cnt_b", n), {16'd0, cnt_b}, (n >= 65535) ? 32'h0000FFFF : n);
      end
    end
    @(negedge clk);
    req = 3'b000;
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pdp8_mem_arb_ctrl.md
Name: pdp8_mem_arb_ctrl

Overview:
Parametrised successor to the single-requester PDP-8 memory stub. It lets NUM_CH requesters share one internal word-addressed memory, such as instruction fetch, exec read and exec write. It arbitrates one access per cycle, returns read data through a configurable-latency pipeline, and routes each response back to the channel that issued it. It sits between the decode/exec units and main memory in the PDP-8 datapath.

Parameters:
NUM_CH, 3, number of requester channels (1..8)
ADDR_WIDTH, 12, word address width; memory depth is 2**ADDR_WIDTH
DATA_WIDTH, 12, word width
RD_LAT, 2, cycles from read grant edge to rvalid (1..4)
ARB_MODE, 0, 0 = fixed priority (channel 0 highest), 1 = round-robin

Ports:
clk  in  1  clock, all state updates on rising edge
reset  in  1  asynchronous, active-high reset
req  in  NUM_CH  per-channel request, held until granted
we  in  NUM_CH  per-channel write enable (1 = write, 0 = read), valid with req
addr  in  NUM_CH*ADDR_WIDTH  per-channel address, channel i at [i*ADDR_WIDTH +: ADDR_WIDTH]
wdata  in  NUM_CH*DATA_WIDTH  per-channel write data, same packing
gnt  out  NUM_CH  one-hot grant, combinational from req and arbiter state
rvalid  out  NUM_CH  one-hot read-response valid, registered
rdata  out  DATA_WIDTH  read data, valid when any rvalid bit is set
acc_cnt  out  16  count of granted accesses, saturating at 16'hFFFF

Behaviour:
- Reset (async assert, sync release):
  - rvalid = 0, rdata = 0, acc_cnt = 0.
  - Round-robin pointer = 0.
  - Read pipeline flushed; in-flight reads are dropped and never produce rvalid.
  - Memory contents are NOT cleared.
  - gnt = 0 while reset is high.
- Handshake:
  - A channel's transaction is accepted at the rising edge where req[i] & gnt[i] = 1.
  - Requester holds req, we, addr and wdata stable until granted.
  - At most one gnt bit is set per cycle; gnt = 0 when req = 0.
- Arbitration:
  - ARB_MODE 0: lowest-index requesting channel wins.
  - ARB_MODE 1: search starts at the pointer and wraps modulo NUM_CH. After a grant to channel k, pointer = (k+1) mod NUM_CH. With no grant, the pointer is unchanged.
- Write:
  - mem[addr] <= wdata at the accept edge.
  - No response is generated.
- Read:
  - Memory is sampled at the accept edge; {channel id, data} enter a RD_LAT-deep shift pipeline.
  - rvalid[i] and rdata are asserted exactly RD_LAT cycles after the accept edge, for one cycle.
  - Back-to-back reads give back-to-back responses in grant order.
- Ordering:
  - A read accepted in the cycle after a write to the same address returns the new data.
  - A write and a read to the same address can never be accepted in the same cycle (single port).
- Read response: when no response is due, rvalid = 0 and rdata holds its last value.
- Address: full ADDR_WIDTH is used; no out-of-range case exists.
- Counters: acc_cnt increments by 1 per accepted read or write and saturates at 16'hFFFF (no wrap).
- Starvation: fixed-priority mode may starve high-index channels by design. Round-robin mode guarantees a grant within NUM_CH cycles of a held req.
- Reset mid-operation: pending req is not granted; the pointer returns to 0.

Test Plan:
1. Write then read, RD_LAT=2, NUM_CH=3:
   - ch1 write addr 12'o0100 data 12'o7654; next cycle ch1 read 12'o0100.
   - gnt[1] each cycle; rvalid = 3'b010 with rdata = 12'o7654 exactly 2 cycles after the read grant.
2. Fixed-priority contention, ARB_MODE=0:
   - req = 3'b111 held for 3 cycles, all reads.
   - gnt = 3'b001 every cycle; ch1 and ch2 never granted; acc_cnt = 3.
3. Round-robin, ARB_MODE=1:
   - req = 3'b111 held for 6 cycles.
   - gnt sequence 001, 010, 100, 001, 010, 100; rvalid follows the same sequence delayed by RD_LAT.
4. Pipelined reads, RD_LAT=4:
   - Preload 12'o0001..12'o0004 at addrs 0..3; ch0 reads addrs 0..3 on consecutive cycles.
   - rvalid[0] high for 4 consecutive cycles starting 4 cycles after the first grant; rdata = 1, 2, 3, 4.
5. Reset mid-flight:
   - Issue a read, then assert reset 1 cycle later for 2 cycles.
   - No rvalid ever appears for that read; mem contents are intact on re-read after reset; acc_cnt = 0.
6. Counter saturation:
   - Force 65540 accepted accesses.
   - acc_cnt stops at 16'hFFFF and does not wrap to 0.
